vga_pattern_gen: RTL and testbench

VGA_PATTERN_GEN -- requirements
Module: vga_pattern_gen

---
 rtl/vga_pattern_gen.sv | 154 +++++++++++++++
 tb/tb_vga_pattern_gen.sv | 233 +++++++++++++++++++++++
 2 files changed

// File: rtl/vga_pattern_gen.sv
// vga_pattern_gen -- test pattern source for a VGA controller.
//
// Renders one of four patterns from the controller's pixel coordinates, with
// one cycle of latency. The pattern mode is sampled only at frame start (the
// valid pixel at X=0, Y=0), so a mode change never tears a frame.
//
// Ports:
//   iCLK, iRST_N           pixel clock, asynchronous active-low reset
//   iMODE[1:0]             requested pattern (0 tile, 1 bars, 2 checker, 3 scroll)
//   iCurrent_X/Y[9:0]      pixel coordinates from the VGA controller
//   iVALID                 pixel lies in the display window
//   oRed/oGreen/oBlue      registered colour, COLOR_W bits each
//   oVALID                 iVALID delayed to line up with the colour outputs
//   oFRAME_CNT[7:0]        frame starts seen since reset (wraps)
//
// Build option: define VGA_PATTERN_BORDER_EN to paint a one-pixel white frame
// around the active area on top of every pattern.
module vga_pattern_gen #(
  parameter int COLOR_W   = 10,
  parameter int H_ACTIVE  = 640,
  parameter int V_ACTIVE  = 480,
  parameter int TILE_LOG2 = 6
) (
  input  logic               iCLK,
  input  logic               iRST_N,
  input  logic [1:0]         iMODE,
  input  logic [9:0]         iCurrent_X,
  input  logic [9:0]         iCurrent_Y,
  input  logic               iVALID,
  output logic [COLOR_W-1:0] oRed,
  output logic [COLOR_W-1:0] oGreen,
  output logic [COLOR_W-1:0] oBlue,
  output logic               oVALID,
  output logic [7:0]         oFRAME_CNT
);

  localparam logic [COLOR_W-1:0] C_MAX = '1;
  localparam logic [COLOR_W-1:0] C_BG  = COLOR_W'(1) << (COLOR_W - 3);

  logic [1:0]         mode_q,  mode_d;
  logic [7:0]         cnt_q,   cnt_d;
  logic [9:0]         bar_q,   bar_d;
  logic [COLOR_W-1:0] red_q,   red_d;
  logic [COLOR_W-1:0] green_q, green_d;
  logic [COLOR_W-1:0] blue_q,  blue_d;
  logic               vld_q,   vld_d;

  logic        frame_start;
  logic        active;
  logic [12:0] x_times8;
  logic [2:0]  bar_idx;
  logic [10:0] bar_dist;
  logic        chk_white;

  always_comb begin
    frame_start = iVALID && (iCurrent_X == 10'd0) && (iCurrent_Y == 10'd0);
    active      = iVALID && ({1'b0, iCurrent_X} < 11'(H_ACTIVE))
                         && ({1'b0, iCurrent_Y} < 11'(V_ACTIVE));

    // Frame-level state advances at frame start; the frame-start pixel itself
    // is rendered from the *_d values so it already uses the new mode/count.
    mode_d = mode_q;
    cnt_d  = cnt_q;
    bar_d  = bar_q;
    if (frame_start) begin
      mode_d = iMODE;
      cnt_d  = cnt_q + 8'd1;
      bar_d  = (bar_q == 10'(V_ACTIVE - 1)) ? 10'd0 : bar_q + 10'd1;
    end

    // Colour-bar index = X*8/H_ACTIVE, only meaningful for X < H_ACTIVE.
    x_times8 = {iCurrent_X, 3'b000};
    bar_idx  = 3'(x_times8 / 13'(H_ACTIVE));

    // Distance of this line below the bar top, modulo V_ACTIVE, so the bar
    // wraps cleanly from the bottom line to the top.
    if (iCurrent_Y >= bar_d)
      bar_dist = {1'b0, iCurrent_Y} - {1'b0, bar_d};
    else
      bar_dist = {1'b0, iCurrent_Y} + 11'(V_ACTIVE) - {1'b0, bar_d};

    chk_white = iCurrent_X[TILE_LOG2] ^ iCurrent_Y[TILE_LOG2] ^ cnt_d[5];

    red_d   = '0;
    green_d = '0;
    blue_d  = '0;
    if (active) begin
      unique case (mode_d)
        2'd0: begin
          red_d   = COLOR_W'(iCurrent_X[TILE_LOG2-1:0]) << (COLOR_W - TILE_LOG2);
          green_d = COLOR_W'(iCurrent_Y[TILE_LOG2-1:0]) << (COLOR_W - TILE_LOG2);
          blue_d  = COLOR_W'({iCurrent_X[9:6], iCurrent_Y[9:6]}) << (COLOR_W - 8);
        end
        2'd1: begin
          // white, yellow, cyan, green, magenta, red, blue, black
          red_d   = bar_idx[1] ? '0 : C_MAX;
          green_d = bar_idx[2] ? '0 : C_MAX;
          blue_d  = bar_idx[0] ? '0 : C_MAX;
        end
        2'd2: begin
          red_d   = chk_white ? C_MAX : '0;
          green_d = chk_white ? C_MAX : '0;
          blue_d  = chk_white ? C_MAX : '0;
        end
        default: begin
          if (bar_dist < 11'd16) begin
            green_d = C_MAX;
          end else begin
            red_d   = C_BG;
            green_d = C_BG;
            blue_d  = C_BG;
          end
        end
      endcase
`ifdef VGA_PATTERN_BORDER_EN
      if ((iCurrent_X == 10'd0) || (iCurrent_X == 10'(H_ACTIVE - 1)) ||
          (iCurrent_Y == 10'd0) || (iCurrent_Y == 10'(V_ACTIVE - 1))) begin
        red_d   = C_MAX;
        green_d = C_MAX;
        blue_d  = C_MAX;
      end
`endif
    end

    vld_d = iVALID;
  end

  always_ff @(posedge iCLK or negedge iRST_N) begin
    if (!iRST_N) begin
      mode_q  <= '0;
      cnt_q   <= '0;
      bar_q   <= '0;
      red_q   <= '0;
      green_q <= '0;
      blue_q  <= '0;
      vld_q   <= 1'b0;
    end else begin
      mode_q  <= mode_d;
      cnt_q   <= cnt_d;
      bar_q   <= bar_d;
      red_q   <= red_d;
      green_q <= green_d;
      blue_q  <= blue_d;
      vld_q   <= vld_d;
    end
  end

  assign oRed       = red_q;
  assign oGreen     = green_q;
  assign oBlue      = blue_q;
  assign oVALID     = vld_q;
  assign oFRAME_CNT = cnt_q;

endmodule

// File: tb/tb_vga_pattern_gen.sv
module tb_vga_pattern_gen;

  localparam int CW = 10;
`ifdef VGA_PATTERN_BORDER_EN
  localparam bit BORDER = 1'b1;
`else
  localparam bit BORDER = 1'b0;
`endif
  localparam logic [3*CW-1:0] WHITE  = {10'd1023, 10'd1023, 10'd1023};
  localparam logic [3*CW-1:0] BLACK  = '0;
  localparam logic [3*CW-1:0] GREEN  = {10'd0, 10'd1023, 10'd0};
  localparam logic [3*CW-1:0] GREY   = {10'd128, 10'd128, 10'd128};

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic [1:0]    mode = 2'd0;
  logic [9:0]    px = '0, py = '0;
  logic          vin = 1'b0;
  logic [CW-1:0] red, green, blue;
  logic          vout;
  logic [7:0]    fcnt;
  logic [3*CW-1:0] got;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  vga_pattern_gen #(.COLOR_W(CW), .H_ACTIVE(640), .V_ACTIVE(480), .TILE_LOG2(6)) dut (
    .iCLK(clk), .iRST_N(rst_n), .iMODE(mode), .iCurrent_X(px), .iCurrent_Y(py),
    .iVALID(vin), .oRed(red), .oGreen(green), .oBlue(blue), .oVALID(vout),
    .oFRAME_CNT(fcnt)
  );

  assign got = {red, green, blue};

  // Present one pixel, clock it, and settle just after the edge.
  task automatic pix(input logic [9:0] x, input logic [9:0] y, input logic v,
                     input logic [1:0] m);
    px = x; py = y; vin = v; mode = m;
    @(posedge clk); #1;
  endtask

  // Edge pixels turn white when the border option is built in.
  function automatic logic [3*CW-1:0] bexp(input int x, input int y,
                                           input logic [3*CW-1:0] e);
    if (BORDER && (x == 0 || x == 639 || y == 0 || y == 479)) return WHITE;
    return e;
  endfunction

  task automatic do_reset();
    rst_n = 1'b0; vin = 1'b0; px = '0; py = '0; mode = 2'd0;
    @(posedge clk); #1;
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; vin = 1'b1; px = 10'd65; py = 10'd130; mode = 2'd1;
    @(posedge clk); #1;
    checks++;
    if (got !== BLACK || vout !== 1'b0 || fcnt !== 8'd0) begin
      errors++;
      $display("FAIL reset_state: rgb=%h vld=%b cnt=%0d want rgb=0 vld=0 cnt=0", got, vout, fcnt);
    end
    rst_n = 1'b1;
  endtask

  task automatic test_tile();
    logic [3*CW-1:0] e;
    // iMODE=2 mid-frame after reset must be ignored: still tile gradient.
    pix(10'd65, 10'd130, 1'b1, 2'd2);
    e = {10'd16, 10'd32, 10'h048};
    checks++;
    if (got !== e || vout !== 1'b1) begin
      errors++;
      $display("FAIL tile_65_130: rgb=%h vld=%b want rgb=%h vld=1", got, vout, e);
    end
    pix(10'd639, 10'd240, 1'b1, 2'd0);
    e = bexp(639, 240, {10'd1008, 10'd768, 10'd588});
    checks++;
    if (got !== e) begin
      errors++;
      $display("FAIL tile_639_240: rgb=%h want %h", got, e);
    end
  endtask

  task automatic test_blank();
    pix(10'd10, 10'd10, 1'b0, 2'd0);
    checks++;
    if (got !== BLACK || vout !== 1'b0) begin
      errors++;
      $display("FAIL blank_invalid: rgb=%h vld=%b want rgb=0 vld=0", got, vout);
    end
    pix(10'd640, 10'd10, 1'b1, 2'd0);
    checks++;
    if (got !== BLACK || vout !== 1'b1) begin
      errors++;
      $display("FAIL blank_x640: rgb=%h vld=%b want rgb=0 vld=1", got, vout);
    end
    pix(10'd10, 10'd480, 1'b1, 2'd0);
    checks++;
    if (got !== BLACK) begin
      errors++;
      $display("FAIL blank_y480: rgb=%h want 0", got);
    end
  endtask

  task automatic test_mode_change();
    logic [3*CW-1:0] e;
    pix(10'd0, 10'd0, 1'b1, 2'd0);
    e = bexp(0, 0, BLACK);
    checks++;
    if (got !== e || fcnt !== 8'd1) begin
      errors++;
      $display("FAIL fs1: rgb=%h cnt=%0d want rgb=%h cnt=1", got, fcnt, e);
    end
    pix(10'd100, 10'd200, 1'b1, 2'd2);
    e = {10'd576, 10'd128, 10'd76};
    checks++;
    if (got !== e) begin
      errors++;
      $display("FAIL mode_hold_100_200: rgb=%h want %h", got, e);
    end
    pix(10'd0, 10'd0, 1'b1, 2'd2);
    e = bexp(0, 0, BLACK);
    checks++;
    if (got !== e || fcnt !== 8'd2) begin
      errors++;
      $display("FAIL fs2_checker: rgb=%h cnt=%0d want rgb=%h cnt=2", got, fcnt, e);
    end
    pix(10'd64, 10'd1, 1'b1, 2'd0);
    checks++;
    if (got !== WHITE) begin
      errors++;
      $display("FAIL checker_64_1: rgb=%h want %h", got, WHITE);
    end
    pix(10'd100, 10'd200, 1'b1, 2'd1);
    checks++;
    if (got !== BLACK) begin
      errors++;
      $display("FAIL checker_100_200: rgb=%h want 0", got);
    end
  endtask

  task automatic test_bars();
    int xs [7] = '{0, 80, 639, 400, 79, 560, 240};
    logic [3*CW-1:0] es [7];
    es[0] = WHITE;
    es[1] = {10'd1023, 10'd1023, 10'd0};
    es[2] = BLACK;
    es[3] = {10'd1023, 10'd0, 10'd0};
    es[4] = WHITE;
    es[5] = BLACK;
    es[6] = GREEN;
    // Frame start switches to bars; the frame-start pixel already uses them.
    for (int i = 0; i < 7; i++) begin
      pix(10'(xs[i]), (i == 0) ? 10'd0 : 10'd10, 1'b1, 2'd1);
      checks++;
      if (got !== bexp(xs[i], (i == 0) ? 0 : 10, es[i])) begin
        errors++;
        $display("FAIL bars_x%0d: rgb=%h want %h", xs[i], got,
                 bexp(xs[i], (i == 0) ? 0 : 10, es[i]));
      end
    end
  endtask

  task automatic test_checker_frames();
    int      ks [6] = '{1, 31, 32, 64, 255, 256};
    logic [7:0] cs [6] = '{8'd1, 8'd31, 8'd32, 8'd64, 8'd255, 8'd0};
    bit      ws [6] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0};
    int      j = 0;
    do_reset();
    for (int k = 1; k <= 256; k++) begin
      pix(10'd0, 10'd0, 1'b1, 2'd2);
      if (j < 6 && k == ks[j]) begin
        checks++;
        if (got !== bexp(0, 0, ws[j] ? WHITE : BLACK) || fcnt !== cs[j]) begin
          errors++;
          $display("FAIL frames_%0d: rgb=%h cnt=%0d want rgb=%h cnt=%0d", k, got, fcnt,
                   bexp(0, 0, ws[j] ? WHITE : BLACK), cs[j]);
        end
        j++;
      end
    end
  endtask

  task automatic test_scroll();
    int ys1 [6] = '{470, 479, 0, 5, 6, 469};
    bit gs1 [6] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0};
    int ys2 [4] = '{0, 15, 16, 479};
    bit gs2 [4] = '{1'b1, 1'b1, 1'b0, 1'b0};
    do_reset();
    repeat (470) pix(10'd0, 10'd0, 1'b1, 2'd3);
    checks++;
    if (fcnt !== 8'd214) begin
      errors++;
      $display("FAIL scroll_cnt: cnt=%0d want 214", fcnt);
    end
    for (int i = 0; i < 6; i++) begin
      pix(10'd5, 10'(ys1[i]), 1'b1, 2'd0);
      checks++;
      if (got !== bexp(5, ys1[i], gs1[i] ? GREEN : GREY)) begin
        errors++;
        $display("FAIL bar470_y%0d: rgb=%h want %h", ys1[i], got,
                 bexp(5, ys1[i], gs1[i] ? GREEN : GREY));
      end
    end
    // Ten more frames take the bar 470 -> 479 -> 0.
    repeat (10) pix(10'd0, 10'd0, 1'b1, 2'd3);
    for (int i = 0; i < 4; i++) begin
      pix(10'd5, 10'(ys2[i]), 1'b1, 2'd0);
      checks++;
      if (got !== bexp(5, ys2[i], gs2[i] ? GREEN : GREY)) begin
        errors++;
        $display("FAIL bar0_y%0d: rgb=%h want %h", ys2[i], got,
                 bexp(5, ys2[i], gs2[i] ? GREEN : GREY));
      end
    end
  endtask

  initial begin
    test_reset();
    test_tile();
    test_blank();
    test_mode_change();
    test_bars();
    test_checker_frames();
    test_scroll();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
